// File: rtl/subdiv_sequencer.sv
// Phase controller for the subdivision engine: runs pass_count passes of three
// engines in fixed order, owns the shared object-RAM mux and tracks mesh counts.
module subdiv_sequencer #(
  parameter int ADDR_WIDTH  = 9,
  parameter int NUM_ENG     = 3,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          go,
  input  logic [3:0]                    pass_count,
  input  logic [31:0]                   init_vertex_count,
  input  logic [31:0]                   init_face_count,
  input  logic [31:0]                   split_vertex_count,
  input  logic [31:0]                   split_face_count,
  output logic [NUM_ENG-1:0]            eng_start,
  input  logic [NUM_ENG-1:0]            eng_busy,
  input  logic [NUM_ENG-1:0]            eng_ram_en,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_ram_a,
  input  logic [NUM_ENG*4-1:0]          eng_ram_we,
  input  logic [NUM_ENG*32-1:0]         eng_ram_di,
  output logic                          ram_en,
  output logic [ADDR_WIDTH-1:0]         ram_a,
  output logic [3:0]                    ram_we,
  output logic [31:0]                   ram_di,
  output logic [31:0]                   vertex_count,
  output logic [31:0]                   face_count,
  output logic [3:0]                    pass_idx,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic                          conflict
);

  localparam int ENG_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ENG_W-1:0] LAST_ENG = ENG_W'(NUM_ENG - 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, NEXT, FINISH
  } state_t;

  state_t           state;
  logic [ENG_W-1:0] eng_q;
  logic [3:0]       pc_q;
  logic [CNT_W-1:0] ack_cnt;
  logic             own_vld;
  logic             cur_busy;
  logic             wr_viol;

  function automatic logic [NUM_ENG-1:0] eng_onehot(input logic [ENG_W-1:0] e);
    logic [NUM_ENG-1:0] oh;
    oh = '0;
    oh[e] = 1'b1;
    return oh;
  endfunction

  // Shared RAM port follows the current owner; everyone else is dropped and
  // any write attempt from a non-owner is flagged.
  always_comb begin
    own_vld  = (state == LAUNCH) || (state == WAIT_ACK) || (state == WAIT_DONE);
    cur_busy = 1'b0;
    wr_viol  = 1'b0;
    ram_en   = 1'b0;
    ram_a    = '0;
    ram_we   = '0;
    ram_di   = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (own_vld && (eng_q == ENG_W'(i))) begin
        cur_busy = eng_busy[i];
        ram_en   = eng_ram_en[i];
        ram_a    = eng_ram_a[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_we   = eng_ram_we[i*4 +: 4];
        ram_di   = eng_ram_di[i*32 +: 32];
      end else if (|eng_ram_we[i*4 +: 4]) begin
        wr_viol = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      eng_q        <= '0;
      pc_q         <= '0;
      ack_cnt      <= '0;
      eng_start    <= '0;
      pass_idx     <= '0;
      vertex_count <= '0;
      face_count   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      conflict     <= 1'b0;
    end else begin
      eng_start <= '0;
      done      <= 1'b0;
      if (wr_viol)
        conflict <= 1'b1;
      case (state)
        IDLE: begin
          if (go) begin
            pc_q         <= pass_count;
            vertex_count <= init_vertex_count;
            face_count   <= init_face_count;
            error        <= 1'b0;
            conflict     <= 1'b0;
            pass_idx     <= '0;
            eng_q        <= '0;
            if (pass_count == 4'd0) begin
              state <= FINISH;
            end else begin
              state     <= LAUNCH;
              busy      <= 1'b1;
              eng_start <= eng_onehot('0);
            end
          end
        end
        LAUNCH: begin
          ack_cnt <= '0;
          state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (cur_busy) begin
            state <= WAIT_DONE;
          end else if (ack_cnt == ACK_LAST) begin
            error <= 1'b1;
            state <= FINISH;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!cur_busy) begin
            // Splitter results become the counts seen by the rest of this pass.
            if (eng_q == '0) begin
              vertex_count <= split_vertex_count;
              face_count   <= split_face_count;
            end
            state <= NEXT;
          end
        end
        NEXT: begin
          if (eng_q != LAST_ENG) begin
            eng_q     <= eng_q + 1'b1;
            eng_start <= eng_onehot(eng_q + 1'b1);
            state     <= LAUNCH;
          end else if (pass_idx == pc_q - 4'd1) begin
            state <= FINISH;
          end else begin
            pass_idx  <= pass_idx + 4'd1;
            eng_q     <= '0;
            eng_start <= eng_onehot('0);
            state     <= LAUNCH;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subdiv_sequencer.sv
// Bench for subdiv_sequencer: stub engines with programmable busy length plus
// scoreboards for start-pulse order and splitter count updates.
module tb_subdiv_sequencer;

  logic        clk;
  logic        rst, go;
  logic [3:0]  pass_count;
  logic [31:0] init_vertex_count, init_face_count;
  logic [31:0] split_vertex_count, split_face_count;
  logic [2:0]  eng_start, eng_busy, eng_ram_en;
  logic [26:0] eng_ram_a;
  logic [11:0] eng_ram_we;
  logic [95:0] eng_ram_di;
  logic        ram_en;
  logic [8:0]  ram_a;
  logic [3:0]  ram_we;
  logic [31:0] ram_di, vertex_count, face_count;
  logic [3:0]  pass_idx;
  logic        busy, done, error, conflict;

  subdiv_sequencer dut (
    .clk(clk), .rst(rst), .go(go), .pass_count(pass_count),
    .init_vertex_count(init_vertex_count), .init_face_count(init_face_count),
    .split_vertex_count(split_vertex_count), .split_face_count(split_face_count),
    .eng_start(eng_start), .eng_busy(eng_busy), .eng_ram_en(eng_ram_en),
    .eng_ram_a(eng_ram_a), .eng_ram_we(eng_ram_we), .eng_ram_di(eng_ram_di),
    .ram_en(ram_en), .ram_a(ram_a), .ram_we(ram_we), .ram_di(ram_di),
    .vertex_count(vertex_count), .face_count(face_count), .pass_idx(pass_idx),
    .busy(busy), .done(done), .error(error), .conflict(conflict)
  );

  int n_cmp, n_fail;
  int stub_len [3];
  bit stub_dead [3];
  logic [6:0]  exp_start [$];
  logic [6:0]  obs_start [$];
  logic [63:0] exp_vc [$];
  logic [63:0] obs_vc [$];
  logic [63:0] split_q [$];
  int cyc_n, done_cnt, busy_cycles, st1_cyc, err_cyc, done_cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stub engines: busy rises the cycle start is seen and stays up stub_len cycles.
  initial begin
    int cnt [3];
    logic [63:0] sp;
    eng_busy = '0;
    split_vertex_count = '0;
    split_face_count = '0;
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (cnt[i] > 0) begin
          cnt[i] = cnt[i] - 1;
          if (cnt[i] == 0) eng_busy[i] = 1'b0;
        end else if (eng_start[i] && !stub_dead[i]) begin
          eng_busy[i] = 1'b1;
          cnt[i] = stub_len[i];
          if (i == 0 && split_q.size() > 0) begin
            sp = split_q.pop_front();
            split_vertex_count = sp[63:32];
            split_face_count = sp[31:0];
          end
        end
      end
    end
  end

  // Observer: records start pulses, counts after splitter completion, and event times.
  initial begin
    bit prev_b0, fell_prev, prev_err;
    cyc_n = 0; done_cnt = 0; busy_cycles = 0;
    st1_cyc = -1; err_cyc = -1; done_cyc = -1;
    prev_b0 = 1'b0; fell_prev = 1'b0; prev_err = 1'b0;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (fell_prev) obs_vc.push_back({vertex_count, face_count});
      fell_prev = prev_b0 && !eng_busy[0];
      prev_b0 = eng_busy[0];
      if (eng_start != 3'b000) obs_start.push_back({pass_idx, eng_start});
      if (eng_start[1]) st1_cyc = cyc_n;
      if (error && !prev_err) err_cyc = cyc_n;
      prev_err = error;
      if (done) begin done_cnt++; done_cyc = cyc_n; end
      if (busy) busy_cycles++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic start_run(input logic [3:0] pc, input logic [31:0] iv, input logic [31:0] ifc);
    @(posedge clk); #1;
    pass_count = pc; init_vertex_count = iv; init_face_count = ifc; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int cyc);
    ok = 1'b0; cyc = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      cyc++;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic clear_sb();
    exp_start.delete(); obs_start.delete(); exp_vc.delete(); obs_vc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (eng_start !== 3'b000) begin n_fail++; $display("FAIL reset_eng_start got=%b exp=000", eng_start); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b exp=0", error); end
    n_cmp++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict got=%b exp=0", conflict); end
    n_cmp++; if (vertex_count !== 32'd0 || face_count !== 32'd0) begin n_fail++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", vertex_count, face_count); end
    n_cmp++; if (pass_idx !== 4'd0) begin n_fail++; $display("FAIL reset_pass_idx got=%0d exp=0", pass_idx); end
    n_cmp++; if (ram_en !== 1'b0 || ram_we !== 4'h0) begin n_fail++; $display("FAIL reset_ram got=%b/%h exp=0/0", ram_en, ram_we); end
  endtask

  task automatic test_single_pass();
    bit ok; int cyc, d0; logic [6:0] e7, o7; logic [63:0] e64, o64;
    clear_sb();
    split_q.push_back({32'd26, 32'd24});
    exp_start.push_back({4'd0, 3'b001}); exp_start.push_back({4'd0, 3'b010}); exp_start.push_back({4'd0, 3'b100});
    exp_vc.push_back({32'd26, 32'd24});
    d0 = done_cnt;
    start_run(4'd1, 32'd8, 32'd6);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy); end
    n_cmp++; if (vertex_count !== 32'd8 || face_count !== 32'd6) begin n_fail++; $display("FAIL single_init_counts got=%0d/%0d exp=8/6", vertex_count, face_count); end
    wait_done(200, ok, cyc);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_done_timeout got=none exp=done within 200"); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_at_done got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL single_done_count got=%0d exp=1", done_cnt - d0); end
    n_cmp++; if (obs_start.size() != exp_start.size()) begin n_fail++; $display("FAIL single_start_count got=%0d exp=%0d", obs_start.size(), exp_start.size()); end
    while (exp_start.size() > 0 && obs_start.size() > 0) begin
      e7 = exp_start.pop_front(); o7 = obs_start.pop_front(); n_cmp++;
      if (o7 !== e7) begin n_fail++; $display("FAIL single_start got=%h exp=%h", o7, e7); end
    end
    n_cmp++; if (obs_vc.size() != exp_vc.size()) begin n_fail++; $display("FAIL single_vc_count got=%0d exp=%0d", obs_vc.size(), exp_vc.size()); end
    while (exp_vc.size() > 0 && obs_vc.size() > 0) begin
      e64 = exp_vc.pop_front(); o64 = obs_vc.pop_front(); n_cmp++;
      if (o64 !== e64) begin n_fail++; $display("FAIL single_counts got=%h exp=%h", o64, e64); end
    end
  endtask

  task automatic test_two_pass();
    bit ok; int cyc; logic [6:0] e7, o7; logic [63:0] e64, o64;
    clear_sb();
    split_q.push_back({32'd26, 32'd24}); split_q.push_back({32'd98, 32'd96});
    for (int p = 0; p < 2; p++) begin
      exp_start.push_back({4'(p), 3'b001}); exp_start.push_back({4'(p), 3'b010}); exp_start.push_back({4'(p), 3'b100});
    end
    exp_vc.push_back({32'd26, 32'd24}); exp_vc.push_back({32'd98, 32'd96});
    start_run(4'd2, 32'd8, 32'd6);
    wait_done(400, ok, cyc);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL two_done_timeout got=none exp=done within 400"); end
    n_cmp++; if (pass_idx !== 4'd1) begin n_fail++; $display("FAIL two_pass_idx_final got=%0d exp=1", pass_idx); end
    #1;
    n_cmp++; if (obs_start.size() != exp_start.size()) begin n_fail++; $display("FAIL two_start_count got=%0d exp=%0d", obs_start.size(), exp_start.size()); end
    while (exp_start.size() > 0 && obs_start.size() > 0) begin
      e7 = exp_start.pop_front(); o7 = obs_start.pop_front(); n_cmp++;
      if (o7 !== e7) begin n_fail++; $display("FAIL two_start got=%h exp=%h", o7, e7); end
    end
    n_cmp++; if (obs_vc.size() != exp_vc.size()) begin n_fail++; $display("FAIL two_vc_count got=%0d exp=%0d", obs_vc.size(), exp_vc.size()); end
    while (exp_vc.size() > 0 && obs_vc.size() > 0) begin
      e64 = exp_vc.pop_front(); o64 = obs_vc.pop_front(); n_cmp++;
      if (o64 !== e64) begin n_fail++; $display("FAIL two_counts got=%h exp=%h", o64, e64); end
    end
  endtask

  task automatic test_zero_pass();
    bit ok; int cyc, b0, d0;
    clear_sb();
    b0 = busy_cycles; d0 = done_cnt;
    start_run(4'd0, 32'd11, 32'd7);
    wait_done(20, ok, cyc);
    n_cmp++; if (!ok || cyc != 2) begin n_fail++; $display("FAIL zero_done_latency got=%0d ok=%b exp=2", cyc, ok); end
    n_cmp++; if (vertex_count !== 32'd11 || face_count !== 32'd7) begin n_fail++; $display("FAIL zero_counts got=%0d/%0d exp=11/7", vertex_count, face_count); end
    #1;
    n_cmp++; if (busy_cycles != b0) begin n_fail++; $display("FAIL zero_busy got=%0d cycles exp=0", busy_cycles - b0); end
    n_cmp++; if (obs_start.size() != 0) begin n_fail++; $display("FAIL zero_starts got=%0d exp=0", obs_start.size()); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_ack_timeout();
    bit ok; int cyc; logic [6:0] e7, o7; logic [63:0] e64, o64;
    clear_sb();
    stub_dead[1] = 1'b1;
    split_q.push_back({32'd40, 32'd30});
    exp_start.push_back({4'd0, 3'b001}); exp_start.push_back({4'd0, 3'b010});
    exp_vc.push_back({32'd40, 32'd30});
    start_run(4'd3, 32'd8, 32'd6);
    wait_done(200, ok, cyc);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL timeout_done got=none exp=done within 200"); end
    n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL timeout_error got=%b exp=1", error); end
    #1;
    n_cmp++; if (err_cyc - st1_cyc != 9) begin n_fail++; $display("FAIL timeout_error_time got=%0d exp=9", err_cyc - st1_cyc); end
    n_cmp++; if (done_cyc - st1_cyc != 10) begin n_fail++; $display("FAIL timeout_done_time got=%0d exp=10", done_cyc - st1_cyc); end
    repeat (3) @(negedge clk);
    n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL timeout_error_sticky got=%b exp=1", error); end
    #1;
    n_cmp++; if (obs_start.size() != exp_start.size()) begin n_fail++; $display("FAIL timeout_start_count got=%0d exp=%0d", obs_start.size(), exp_start.size()); end
    while (exp_start.size() > 0 && obs_start.size() > 0) begin
      e7 = exp_start.pop_front(); o7 = obs_start.pop_front(); n_cmp++;
      if (o7 !== e7) begin n_fail++; $display("FAIL timeout_start got=%h exp=%h", o7, e7); end
    end
    while (exp_vc.size() > 0 && obs_vc.size() > 0) begin
      e64 = exp_vc.pop_front(); o64 = obs_vc.pop_front(); n_cmp++;
      if (o64 !== e64) begin n_fail++; $display("FAIL timeout_counts got=%h exp=%h", o64, e64); end
    end
    stub_dead[1] = 1'b0;
  endtask

  task automatic test_conflict();
    bit ok, seen; int cyc; logic [6:0] e7, o7;
    clear_sb();
    stub_len[2] = 10;
    split_q.push_back({32'd12, 32'd10});
    exp_start.push_back({4'd0, 3'b001}); exp_start.push_back({4'd0, 3'b010}); exp_start.push_back({4'd0, 3'b100});
    start_run(4'd1, 32'd8, 32'd6);
    @(negedge clk);
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL go_clears_error got=%b exp=0", error); end
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (eng_start[2]) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL conflict_eng2_start got=none exp=start within 100"); end
    n_cmp++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL conflict_pre got=%b exp=0", conflict); end
    eng_ram_en = 3'b101;
    eng_ram_a  = {9'd5, 9'd0, 9'd7};
    eng_ram_we = {4'hF, 4'h0, 4'hF};
    eng_ram_di = {32'h0000DEAD, 32'h0, 32'h0000BEEF};
    #1;
    n_cmp++; if (ram_en !== 1'b1 || ram_a !== 9'd5) begin n_fail++; $display("FAIL conflict_ram_addr got=%b/%0d exp=1/5", ram_en, ram_a); end
    n_cmp++; if (ram_we !== 4'hF || ram_di !== 32'h0000DEAD) begin n_fail++; $display("FAIL conflict_ram_data got=%h/%h exp=f/0000dead", ram_we, ram_di); end
    @(negedge clk);
    n_cmp++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL conflict_set got=%b exp=1", conflict); end
    eng_ram_en = '0; eng_ram_a = '0; eng_ram_we = '0; eng_ram_di = '0;
    wait_done(200, ok, cyc);
    n_cmp++; if (!ok || conflict !== 1'b1) begin n_fail++; $display("FAIL conflict_sticky got=%b ok=%b exp=1", conflict, ok); end
    @(negedge clk);
    eng_ram_en = 3'b010; eng_ram_a = {9'd0, 9'd3, 9'd0}; eng_ram_we = {4'h0, 4'hF, 4'h0};
    #1;
    n_cmp++; if (ram_en !== 1'b0 || ram_we !== 4'h0) begin n_fail++; $display("FAIL noowner_ram got=%b/%h exp=0/0", ram_en, ram_we); end
    eng_ram_en = '0; eng_ram_a = '0; eng_ram_we = '0;
    n_cmp++; if (obs_start.size() != exp_start.size()) begin n_fail++; $display("FAIL conflict_start_count got=%0d exp=%0d", obs_start.size(), exp_start.size()); end
    while (exp_start.size() > 0 && obs_start.size() > 0) begin
      e7 = exp_start.pop_front(); o7 = obs_start.pop_front(); n_cmp++;
      if (o7 !== e7) begin n_fail++; $display("FAIL conflict_start got=%h exp=%h", o7, e7); end
    end
    stub_len[2] = 5;
  endtask

  task automatic test_reset_mid_run();
    bit ok, seen; int cyc, d0; logic [6:0] e7, o7; logic [63:0] e64, o64;
    clear_sb();
    stub_len[1] = 10;
    split_q.delete();
    split_q.push_back({32'd50, 32'd40});
    start_run(4'd2, 32'd8, 32'd6);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (eng_start[1]) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL midrst_eng1_start got=none exp=start within 100"); end
    repeat (3) @(negedge clk);
    eng_ram_en = 3'b010;
    #1;
    n_cmp++; if (ram_en !== 1'b1) begin n_fail++; $display("FAIL midrst_owned_ram got=%b exp=1", ram_en); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    d0 = done_cnt;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_done got=%b/%b exp=0/0", busy, done); end
    n_cmp++; if (ram_en !== 1'b0 || eng_start !== 3'b000) begin n_fail++; $display("FAIL midrst_idle got=%b/%b exp=0/000", ram_en, eng_start); end
    n_cmp++; if (vertex_count !== 32'd0 || pass_idx !== 4'd0) begin n_fail++; $display("FAIL midrst_outputs got=%0d/%0d exp=0/0", vertex_count, pass_idx); end
    eng_ram_en = '0;
    repeat (4) @(negedge clk);
    #1;
    n_cmp++; if (done_cnt != d0) begin n_fail++; $display("FAIL midrst_no_done got=%0d exp=0", done_cnt - d0); end
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (eng_busy == 3'b000) seen = 1'b1;
    end
    clear_sb();
    split_q.push_back({32'd77, 32'd66});
    exp_start.push_back({4'd0, 3'b001}); exp_start.push_back({4'd0, 3'b010}); exp_start.push_back({4'd0, 3'b100});
    exp_vc.push_back({32'd77, 32'd66});
    start_run(4'd1, 32'd4, 32'd2);
    wait_done(200, ok, cyc);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL midrst_rerun_done got=none exp=done within 200"); end
    #1;
    n_cmp++; if (obs_start.size() != exp_start.size()) begin n_fail++; $display("FAIL midrst_start_count got=%0d exp=%0d", obs_start.size(), exp_start.size()); end
    while (exp_start.size() > 0 && obs_start.size() > 0) begin
      e7 = exp_start.pop_front(); o7 = obs_start.pop_front(); n_cmp++;
      if (o7 !== e7) begin n_fail++; $display("FAIL midrst_start got=%h exp=%h", o7, e7); end
    end
    while (exp_vc.size() > 0 && obs_vc.size() > 0) begin
      e64 = exp_vc.pop_front(); o64 = obs_vc.pop_front(); n_cmp++;
      if (o64 !== e64) begin n_fail++; $display("FAIL midrst_counts got=%h exp=%h", o64, e64); end
    end
    stub_len[1] = 5;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    for (int i = 0; i < 3; i++) begin stub_len[i] = 5; stub_dead[i] = 1'b0; end
    rst = 1'b1; go = 1'b0; pass_count = '0;
    init_vertex_count = '0; init_face_count = '0;
    eng_ram_en = '0; eng_ram_a = '0; eng_ram_we = '0; eng_ram_di = '0;
    test_reset();
    test_single_pass();
    test_two_pass();
    test_zero_pass();
    test_ack_timeout();
    test_conflict();
    test_reset_mid_run();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
